// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM encodings and defaults.
package icache_pkg;

    localparam int unsigned INDEX_BITS_DEFAULT = 4;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StMiss = 2'd1;
    localparam logic [1:0] StFill = 2'd2;

    function automatic logic [31:0] word_addr(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/icache_array.sv
// Line storage for the instruction cache: valid/tag/data, one combinational read port,
// one synchronous write port, valid bits cleared by synchronous reset.
module icache_array
    import icache_pkg::*;
#(
    parameter int unsigned INDEX_BITS = INDEX_BITS_DEFAULT,
    parameter int unsigned TAG_BITS   = 32 - INDEX_BITS - 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [INDEX_BITS-1:0] rd_idx_in,
    output logic                  rd_valid_out,
    output logic [TAG_BITS-1:0]   rd_tag_out,
    output logic [31:0]           rd_data_out,
    input  logic                  we_in,
    input  logic [INDEX_BITS-1:0] wr_idx_in,
    input  logic [TAG_BITS-1:0]   wr_tag_in,
    input  logic [31:0]           wr_data_in
);

    localparam int unsigned Lines = 2 ** INDEX_BITS;

    logic [Lines-1:0]    valid_q, valid_d;
    logic [TAG_BITS-1:0] tag_q  [Lines];
    logic [31:0]         data_q [Lines];

    always_comb begin
        valid_d = valid_q;
        if (we_in) begin
            valid_d[wr_idx_in] = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag/data need no reset; a line is only trusted once its valid bit is set.
    always_ff @(posedge clk_in) begin
        if (we_in && !rst_in) begin
            tag_q[wr_idx_in]  <= wr_tag_in;
            data_q[wr_idx_in] <= wr_data_in;
        end
    end

    assign rd_valid_out = valid_q[rd_idx_in];
    assign rd_tag_out   = tag_q[rd_idx_in];
    assign rd_data_out  = data_q[rd_idx_in];

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache with combinational hit path and a
// single outstanding refill request to the memory controller.
module icache
    import icache_pkg::*;
#(
    parameter int unsigned INDEX_BITS = INDEX_BITS_DEFAULT
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] addr_in,
    input  logic        clear_in,
    output logic        ready_out,
    output logic [31:0] inst_out,
    output logic        mem_req_out,
    output logic [31:0] mem_addr_out,
    input  logic        mem_done_in,
    input  logic [31:0] mem_data_in
);

    localparam int unsigned TAG_BITS = 32 - INDEX_BITS - 2;

    logic [1:0]            state_q, state_d;
    logic [31:0]           miss_addr_q, miss_addr_d;
    logic                  mem_req_q, mem_req_d;

    logic [INDEX_BITS-1:0] idx, miss_idx;
    logic [TAG_BITS-1:0]   tag, rd_tag;
    logic                  rd_valid;
    logic [31:0]           rd_data;
    logic                  hit;
    logic                  fill_we;

    assign idx      = addr_in[INDEX_BITS+1:2];
    assign tag      = addr_in[31:INDEX_BITS+2];
    assign miss_idx = miss_addr_q[INDEX_BITS+1:2];

    icache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rd_idx_in    (idx),
        .rd_valid_out (rd_valid),
        .rd_tag_out   (rd_tag),
        .rd_data_out  (rd_data),
        .we_in        (fill_we),
        .wr_idx_in    (miss_idx),
        .wr_tag_in    (miss_addr_q[31:INDEX_BITS+2]),
        .wr_data_in   (mem_data_in)
    );

    assign hit     = rd_valid && (rd_tag == tag) && (state_q == StIdle);
    // A pending refill always lands, even under clear_in: the data is correct for miss_addr.
    assign fill_we = rdy_in && (state_q == StMiss) && mem_done_in;

    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        mem_req_d   = mem_req_q;
        if (rdy_in) begin
            case (state_q)
                StIdle: begin
                    if (!hit && !clear_in) begin
                        miss_addr_d = word_addr(addr_in);
                        mem_req_d   = 1'b1;
                        state_d     = StMiss;
                    end
                end
                StMiss: begin
                    if (mem_done_in) begin
                        mem_req_d = 1'b0;
                        state_d   = StFill;
                    end
                end
                StFill:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= StIdle;
            miss_addr_q <= '0;
            mem_req_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            mem_req_q   <= mem_req_d;
        end
    end

    assign ready_out    = hit && !clear_in && rdy_in;
    assign inst_out     = rd_data;
    assign mem_req_out  = mem_req_q;
    assign mem_addr_out = miss_addr_q;

endmodule
